// File: rtl/eth_tx_sched_pkg.sv
// Shared types and constants for the Ethernet TX frame scheduler.
package eth_sched_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // Width of the inter-frame gap counter; at least one bit so IFG_LEN = 0 still elaborates.
  function automatic int gap_w(input int ifg);
    return (ifg > 0) ? $clog2(ifg + 1) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_sched_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last' in cyclic order.
module rr_pick #(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last,
  output logic [$clog2(NUM_SRC)-1:0] grant,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(NUM_SRC);

  int   idx;
  logic found;

  // Scan last+1, last+2, ... wrapping, and keep the first source that is requesting.
  always_comb begin
    grant = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last) + k) % NUM_SRC;
      if (!found && req[IDX_W'(idx)]) begin
        grant = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/eth_tx_sched.sv
// Frame-granular round-robin scheduler sharing one 64-bit TX AXI-Stream between NUM_SRC sources.
// A grant is locked for a whole frame and IFG_LEN idle cycles are forced after each tlast.
// Optional build macro: ETH_TX_SCHED_STATS_EN adds per-source frame counters (frame_cnt).
// Handshake: a beat moves on any rising edge where tvalid and tready are both high; only the
// granted source sees tready (equal to m_axis_tready), all others see 0 and simply wait.
module eth_tx_sched
  import eth_sched_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int IFG_LEN = 15
) (
  input  logic                         user_clk,
  input  logic                         cold_reset,
  input  logic [NUM_SRC*DATA_W-1:0]    s_axis_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]    s_axis_tkeep,
  input  logic [NUM_SRC-1:0]           s_axis_tlast,
  input  logic [NUM_SRC-1:0]           s_axis_tvalid,
  output logic [NUM_SRC-1:0]           s_axis_tready,
  output logic [DATA_W-1:0]            m_axis_tdata,
  output logic [KEEP_W-1:0]            m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         busy,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
`ifdef ETH_TX_SCHED_STATS_EN
  output logic [NUM_SRC*32-1:0]        frame_cnt,
`endif
  output sched_state_t                 dbg_state
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int GAP_W = gap_w(IFG_LEN);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_SRC - 1);
  localparam logic [GAP_W-1:0] GAP_INIT  = (IFG_LEN > 0) ? GAP_W'(IFG_LEN - 1) : '0;

  sched_state_t      state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  pick;
  logic              any_req;
  logic [GAP_W-1:0]  gap_cnt;
  logic              busy_q;
  logic              beat_acc;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (s_axis_tvalid),
    .last    (last_grant),
    .grant   (pick),
    .any_req (any_req)
  );

  // Output mux: the granted source drives the MAC only in XFER; everything is zero otherwise.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state == XFER) begin
      m_axis_tdata         = s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
      m_axis_tkeep         = s_axis_tkeep[int'(grant)*KEEP_W +: KEEP_W];
      m_axis_tlast         = s_axis_tlast[grant];
      m_axis_tvalid        = s_axis_tvalid[grant];
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  assign beat_acc = m_axis_tvalid & m_axis_tready;

  // Scheduler FSM: arbitrate in IDLE, hold the grant until tlast, then count out the gap.
  always_ff @(posedge user_clk) begin
    if (cold_reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_INIT;
      gap_cnt    <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= pick;
            state  <= XFER;
            busy_q <= 1'b1;
          end
        end
        XFER: begin
          if (beat_acc && m_axis_tlast) begin
            last_grant <= grant;
            if (IFG_LEN == 0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_INIT;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign grant_id  = grant;
  assign dbg_state = state;

`ifdef ETH_TX_SCHED_STATS_EN
  // Per-source completed-frame counters; wrap naturally at 2^32.
  always_ff @(posedge user_clk) begin
    if (cold_reset) begin
      frame_cnt <= '0;
    end else if (beat_acc && m_axis_tlast) begin
      frame_cnt[int'(grant)*32 +: 32] <= frame_cnt[int'(grant)*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule
